// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N:1 datapath mux with valid/ready inputs, round-robin or
// fixed-priority arbitration, and a single registered output stage.
module rr_mux_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned MODE  = 0,
    parameter int unsigned SEL_W = $clog2(N)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [N*WIDTH-1:0]   In_Data,
    input  logic [N-1:0]         In_Valid,
    output logic [N-1:0]         In_Ready,
    output logic [WIDTH-1:0]     Out_Data,
    output logic [SEL_W-1:0]     Out_Sel,
    output logic                 Out_Valid,
    input  logic                 Out_Ready
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load;
    logic             gnt_found;
    logic [SEL_W-1:0] gnt_idx;
    logic [N-1:0]     gnt_oh;
    logic [WIDTH-1:0] sel_data;
    int unsigned      scan_base;
    int unsigned      scan_idx;

    // Grant search: rotate from ptr (MODE 0) or from index 0 (MODE 1); first valid wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_oh    = '0;
        scan_idx  = 0;
        scan_base = (MODE == 0) ? 32'(ptr_q) : 0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = scan_base + k;
            if (scan_idx >= N) begin
                scan_idx = scan_idx - N;
            end
            if (!gnt_found && In_Valid[scan_idx]) begin
                gnt_found        = 1'b1;
                gnt_idx          = SEL_W'(scan_idx);
                gnt_oh[scan_idx] = 1'b1;
            end
        end
    end

    // Load/handshake decode and one-hot data select (never feeds In_Ready).
    always_comb begin
        load     = Rst && (|In_Valid) && (!valid_q || Out_Ready);
        In_Ready = load ? gnt_oh : '0;
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_oh[i]) begin
                sel_data = In_Data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state for the output register and round-robin pointer.
    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load) begin
            data_d  = sel_data;
            sel_d   = gnt_idx;
            valid_d = 1'b1;
            if (MODE == 0) begin
                ptr_d = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1);
            end
        end else if (valid_q && Out_Ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign Out_Data  = data_q;
    assign Out_Sel   = sel_q;
    assign Out_Valid = valid_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: three instances (N=4 round-robin, N=4 fixed priority,
// N=3 round-robin) driven from a shared stimulus table and checked against
// a cycle-level behavioural model of the arbiter/output register.
module tb_rr_mux_reg;

    logic Clk = 1'b0;
    logic rst_n;

    logic [127:0] data0, data1;
    logic [23:0]  data2;
    logic [3:0]   iv0, iv1, ir0, ir1;
    logic [2:0]   iv2, ir2;
    logic [31:0]  od0, od1;
    logic [7:0]   od2;
    logic [1:0]   os0, os1, os2;
    logic         ov0, ov1, ov2;
    logic         ordy0, ordy1, ordy2;

    rr_mux_reg #(.WIDTH(32), .N(4), .MODE(0)) dut0 (
        .Clk(Clk), .Rst(rst_n), .In_Data(data0), .In_Valid(iv0), .In_Ready(ir0),
        .Out_Data(od0), .Out_Sel(os0), .Out_Valid(ov0), .Out_Ready(ordy0));
    rr_mux_reg #(.WIDTH(32), .N(4), .MODE(1)) dut1 (
        .Clk(Clk), .Rst(rst_n), .In_Data(data1), .In_Valid(iv1), .In_Ready(ir1),
        .Out_Data(od1), .Out_Sel(os1), .Out_Valid(ov1), .Out_Ready(ordy1));
    rr_mux_reg #(.WIDTH(8), .N(3), .MODE(0)) dut2 (
        .Clk(Clk), .Rst(rst_n), .In_Data(data2), .In_Valid(iv2), .In_Ready(ir2),
        .Out_Data(od2), .Out_Sel(os2), .Out_Valid(ov2), .Out_Ready(ordy2));

    always #5 Clk = ~Clk;

    // Stimulus per instance
    int          nch [3] = '{4, 4, 3};
    int          mode[3] = '{0, 1, 0};
    logic [31:0] cd  [3][4];
    logic [3:0]  cv  [3];
    logic        cr  [3];

    // Reference model state
    logic        m_valid[3];
    logic [31:0] m_data [3];
    int          m_sel  [3];
    int          m_ptr  [3];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs_rdy(int u);
        case (u)
            0:       return 32'(ir0);
            1:       return 32'(ir1);
            default: return 32'(ir2);
        endcase
    endfunction

    function automatic logic [31:0] obs_data(int u);
        case (u)
            0:       return od0;
            1:       return od1;
            default: return 32'(od2);
        endcase
    endfunction

    function automatic logic [31:0] obs_sel(int u);
        case (u)
            0:       return 32'(os0);
            1:       return 32'(os1);
            default: return 32'(os2);
        endcase
    endfunction

    function automatic logic [31:0] obs_valid(int u);
        case (u)
            0:       return 32'(ov0);
            1:       return 32'(ov1);
            default: return 32'(ov2);
        endcase
    endfunction

    // Winner among valid channels: rotating from ptr (round-robin) or from 0.
    function automatic int pick(int u);
        int n = nch[u];
        for (int k = 0; k < n; k++) begin
            int c = (mode[u] == 0) ? (m_ptr[u] + k) % n : k;
            if (cv[u][c]) return c;
        end
        return -1;
    endfunction

    task automatic pack();
        for (int i = 0; i < 4; i++) begin
            data0[i*32 +: 32] = cd[0][i];
            data1[i*32 +: 32] = cd[1][i];
        end
        for (int i = 0; i < 3; i++) begin
            data2[i*8 +: 8] = cd[2][i][7:0];
        end
        iv0 = cv[0];
        iv1 = cv[1];
        iv2 = cv[2][2:0];
        ordy0 = cr[0];
        ordy1 = cr[1];
        ordy2 = cr[2];
    endtask

    // One clock: drive, check In_Ready mid-cycle, advance model, check outputs.
    task automatic cycle();
        int   g [3];
        logic ld[3];
        pack();
        #4;
        for (int u = 0; u < 3; u++) begin
            g[u]  = pick(u);
            ld[u] = rst_n && (g[u] >= 0) && (!m_valid[u] || cr[u]);
            check_eq($sformatf("rdy%0d", u), obs_rdy(u), ld[u] ? (32'd1 << g[u]) : 32'd0);
        end
        @(posedge Clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            if (!rst_n) begin
                m_valid[u] = 1'b0;
                m_data[u]  = '0;
                m_sel[u]   = 0;
                m_ptr[u]   = 0;
            end else if (ld[u]) begin
                m_valid[u] = 1'b1;
                m_data[u]  = cd[u][g[u]];
                m_sel[u]   = g[u];
                if (mode[u] == 0) m_ptr[u] = (g[u] + 1) % nch[u];
            end else if (m_valid[u] && cr[u]) begin
                m_valid[u] = 1'b0;
            end
            check_eq($sformatf("valid%0d", u), obs_valid(u), 32'(m_valid[u]));
            check_eq($sformatf("data%0d", u), obs_data(u), m_data[u]);
            check_eq($sformatf("sel%0d", u), obs_sel(u), 32'(m_sel[u]));
        end
    endtask

    task automatic set_all(input logic [3:0] v, input logic r);
        for (int u = 0; u < 3; u++) begin
            cv[u] = (u == 2) ? (v & 4'b0111) : v;
            cr[u] = r;
        end
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            m_valid[u] = 1'b0;
            m_data[u]  = '0;
            m_sel[u]   = 0;
            m_ptr[u]   = 0;
            for (int i = 0; i < 4; i++) begin
                cd[u][i] = (u == 2) ? 32'h10 + 32'(i) : 32'hA0 + 32'(i);
            end
        end

        // Reset with every channel valid.
        rst_n = 1'b0;
        set_all(4'b1111, 1'b1);
        @(posedge Clk);
        #1;
        cycle();
        cycle();
        check_eq("rst_valid", 32'(ov0), 32'd0);
        check_eq("rst_data", od0, 32'd0);

        // Round-robin sequence A0..A3, A0 with no bubbles.
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check_eq("rr_seq_data", od0, 32'hA0 + 32'(k % 4));
            check_eq("rr_seq_sel", 32'(os0), 32'(k % 4));
            check_eq("rr_seq_valid", 32'(ov0), 32'd1);
        end

        // Back-pressure for 3 cycles, then release.
        set_all(4'b1111, 1'b0);
        repeat (3) cycle();
        check_eq("stall_sel", 32'(os0), 32'd0);
        set_all(4'b1111, 1'b1);
        cycle();
        check_eq("stall_release_sel", 32'(os0), 32'd1);

        // Fixed priority: 1010 keeps granting channel 1, then channel 3.
        set_all(4'b1010, 1'b1);
        repeat (3) cycle();
        check_eq("prio_sel1", 32'(os1), 32'd1);
        set_all(4'b1000, 1'b1);
        cycle();
        check_eq("prio_sel3", 32'(os1), 32'd3);

        // Single word on channel 2, drain, then all valid grants channel 3.
        set_all(4'b0100, 1'b1);
        cycle();
        check_eq("single_sel", 32'(os0), 32'd2);
        set_all(4'b0000, 1'b1);
        cycle();
        check_eq("single_drain", 32'(ov0), 32'd0);
        cycle();
        set_all(4'b1111, 1'b1);
        cycle();
        check_eq("single_next", 32'(os0), 32'd3);

        // Reset while stalled discards the word and clears the pointer.
        set_all(4'b1111, 1'b0);
        cycle();
        rst_n = 1'b0;
        cycle();
        check_eq("rst_stall_valid", 32'(ov0), 32'd0);
        rst_n = 1'b1;
        set_all(4'b1111, 1'b1);
        cycle();
        check_eq("rst_stall_ptr", 32'(os0), 32'd0);

        // Random traffic, back-pressure and occasional resets.
        for (int t = 0; t < 400; t++) begin
            for (int u = 0; u < 3; u++) begin
                cv[u] = 4'($urandom);
                if (u == 2) cv[u] = cv[u] & 4'b0111;
                cr[u] = ($urandom % 4) != 0;
                for (int i = 0; i < 4; i++) begin
                    cd[u][i] = $urandom;
                    if (u == 2) cd[u][i] = cd[u][i] & 32'hFF;
                end
            end
            rst_n = ($urandom % 60) != 0;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
